hbuf_ddr3_pg_xfer: RTL and testbench

// - DDR3-side page mover for the hit buffer; sits between the hbuf_ctrl page req/ack interface and the MIG native app port.
// - On each page request, moves one 4 KiB page (256 x 128-bit words) from the hbuf_ctrl page DPRAM into DDR3 at pg_addr.
// - Runs entirely in the DDR3 UI clock domain; synchronizes pg_req internally and answers with a 4-phase pg_ack.

---
 rtl/hbuf_ddr3_pg_xfer_if.sv | 57 +++++
 rtl/hbuf_ddr3_pg_xfer.sv | 228 ++++++++++++++++++++++
 tb/tb_hbuf_ddr3_pg_xfer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hbuf_ddr3_pg_xfer_if.sv
// Signal bundle between the hit-buffer page mover, hbuf_ctrl (page req/ack + DPRAM) and the MIG app port.
// HBUF_PG_READ_EN adds the DDR3 read-return and DPRAM write-back signals.
interface hbuf_ddr3_pg_xfer_if;
    logic         calib_done;
    logic         pg_req;
    logic         pg_optype;
    logic [27:0]  pg_addr;
    logic         pg_ack;
    logic [7:0]   dpram_rd_addr;
    logic [127:0] dpram_dout;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_rdy;
    logic         busy;
    logic [31:0]  n_pgs_done;
    logic [15:0]  n_bad_ops;
    logic [2:0]   dbg_state;
`ifdef HBUF_PG_READ_EN
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic [7:0]   dpram_wr_addr;
    logic [127:0] dpram_wr_data;
    logic         dpram_wren;

    modport master (
        input  calib_done, pg_req, pg_optype, pg_addr, dpram_dout, app_rdy, app_wdf_rdy,
               app_rd_data, app_rd_data_valid,
        output pg_ack, dpram_rd_addr, app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren,
               app_wdf_end, app_wdf_mask, busy, n_pgs_done, n_bad_ops, dbg_state,
               dpram_wr_addr, dpram_wr_data, dpram_wren
    );
    modport slave (
        output calib_done, pg_req, pg_optype, pg_addr, dpram_dout, app_rdy, app_wdf_rdy,
               app_rd_data, app_rd_data_valid,
        input  pg_ack, dpram_rd_addr, app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren,
               app_wdf_end, app_wdf_mask, busy, n_pgs_done, n_bad_ops, dbg_state,
               dpram_wr_addr, dpram_wr_data, dpram_wren
    );
`else
    modport master (
        input  calib_done, pg_req, pg_optype, pg_addr, dpram_dout, app_rdy, app_wdf_rdy,
        output pg_ack, dpram_rd_addr, app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren,
               app_wdf_end, app_wdf_mask, busy, n_pgs_done, n_bad_ops, dbg_state
    );
    modport slave (
        output calib_done, pg_req, pg_optype, pg_addr, dpram_dout, app_rdy, app_wdf_rdy,
        input  pg_ack, dpram_rd_addr, app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren,
               app_wdf_end, app_wdf_mask, busy, n_pgs_done, n_bad_ops, dbg_state
    );
`endif
endinterface

// File: rtl/hbuf_ddr3_pg_xfer.sv
// DDR3-side page mover: copies one DPRAM page into DDR3 through the MIG app port per pg_req/pg_ack cycle.
// HBUF_PG_READ_EN enables read pages (DDR3 -> DPRAM); otherwise read requests are counted as bad ops.
module hbuf_ddr3_pg_xfer #(
    parameter int P_PG_WORDS     = 256,
    parameter int P_DPRAM_RD_LAT = 2,
    parameter int P_ADDR_INC     = 8
) (
    input logic                  clk,
    input logic                  rst,
    hbuf_ddr3_pg_xfer_if.master  bus
);
    // valid/ready: a beat moves on a cycle with valid and ready both high; valid holds until then.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_FWAIT = 3'd2,
        S_ISSUE = 3'd3,
        S_ACK   = 3'd4
    } state_t;

    localparam logic [7:0]  LAST_WORD = 8'(P_PG_WORDS - 1);
    localparam logic [1:0]  LAT_LAST  = 2'(P_DPRAM_RD_LAT - 1);
    localparam logic [27:0] ADDR_INC  = 28'(P_ADDR_INC);

    state_t       state_q, state_d;
    logic         req_s1_q, req_s1_d, req_s2_q, req_s2_d;
    logic         op_rd_q, op_rd_d;
    logic [7:0]   word_cnt_q, word_cnt_d;
    logic [1:0]   wait_cnt_q, wait_cnt_d;
    logic [7:0]   rd_addr_q, rd_addr_d;
    logic [27:0]  app_addr_q, app_addr_d;
    logic [2:0]   app_cmd_q, app_cmd_d;
    logic         app_en_q, app_en_d;
    logic         wren_q, wren_d;
    logic [127:0] wdata_q, wdata_d;
    logic         pg_ack_q, pg_ack_d;
    logic         busy_q, busy_d;
    logic [31:0]  n_pgs_q, n_pgs_d;
    logic [15:0]  n_bad_q, n_bad_d;
`ifdef HBUF_PG_READ_EN
    logic [7:0]   rd_cnt_q, rd_cnt_d;
    logic         rd_all_q, rd_all_d;
    logic [7:0]   wr_addr_q, wr_addr_d;
    logic [127:0] wr_data_q, wr_data_d;
    logic         wr_en_q, wr_en_d;
`endif

    always_comb begin
        state_d    = state_q;
        req_s1_d   = bus.pg_req;
        req_s2_d   = req_s1_q;
        op_rd_d    = op_rd_q;
        word_cnt_d = word_cnt_q;
        wait_cnt_d = wait_cnt_q;
        rd_addr_d  = rd_addr_q;
        app_addr_d = app_addr_q;
        app_cmd_d  = app_cmd_q;
        app_en_d   = app_en_q;
        wren_d     = wren_q;
        wdata_d    = wdata_q;
        pg_ack_d   = pg_ack_q;
        n_pgs_d    = n_pgs_q;
        n_bad_d    = n_bad_q;
`ifdef HBUF_PG_READ_EN
        rd_cnt_d  = rd_cnt_q;
        rd_all_d  = rd_all_q;
        wr_en_d   = bus.app_rd_data_valid;
        wr_addr_d = rd_cnt_q;
        wr_data_d = bus.app_rd_data;
        if (bus.app_rd_data_valid) begin
            rd_cnt_d = rd_cnt_q + 8'd1;
            if (rd_cnt_q == LAST_WORD) rd_all_d = 1'b1;
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (req_s2_q && !pg_ack_q && bus.calib_done) begin
                    app_addr_d = bus.pg_addr;
                    op_rd_d    = bus.pg_optype;
                    word_cnt_d = 8'd0;
                    rd_addr_d  = 8'd0;
                    if (bus.pg_optype) begin
`ifdef HBUF_PG_READ_EN
                        app_cmd_d = 3'b001;
                        app_en_d  = 1'b1;
                        rd_cnt_d  = 8'd0;
                        rd_all_d  = 1'b0;
                        state_d   = S_ISSUE;
`else
                        if (n_bad_q != 16'hFFFF) n_bad_d = n_bad_q + 16'd1;
                        pg_ack_d = 1'b1;
                        n_pgs_d  = n_pgs_q + 32'd1;
                        state_d  = S_ACK;
`endif
                    end else begin
                        app_cmd_d = 3'b000;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                wait_cnt_d = 2'd0;
                state_d    = S_FWAIT;
            end
            S_FWAIT: begin
                // The DPRAM address was already presented during FETCH, so LAT cycles here suffice.
                if (wait_cnt_q == LAT_LAST) begin
                    wdata_d  = bus.dpram_dout;
                    app_en_d = 1'b1;
                    wren_d   = 1'b1;
                    state_d  = S_ISSUE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            S_ISSUE: begin
                if (op_rd_q) begin
`ifdef HBUF_PG_READ_EN
                    if (app_en_q && bus.app_rdy) begin
                        app_addr_d = app_addr_q + ADDR_INC;
                        word_cnt_d = word_cnt_q + 8'd1;
                        app_en_d   = (word_cnt_q != LAST_WORD);
                    end
                    if (!app_en_q && rd_all_q) begin
                        pg_ack_d = 1'b1;
                        n_pgs_d  = n_pgs_q + 32'd1;
                        state_d  = S_ACK;
                    end
`endif
                end else begin
                    app_en_d = app_en_q && !bus.app_rdy;
                    wren_d   = wren_q && !bus.app_wdf_rdy;
                    if (!app_en_d && !wren_d) begin
                        app_addr_d = app_addr_q + ADDR_INC;
                        word_cnt_d = word_cnt_q + 8'd1;
                        rd_addr_d  = word_cnt_q + 8'd1;
                        if (word_cnt_q == LAST_WORD) begin
                            pg_ack_d = 1'b1;
                            n_pgs_d  = n_pgs_q + 32'd1;
                            state_d  = S_ACK;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            S_ACK: begin
                if (!req_s2_q) begin
                    pg_ack_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_s1_q   <= 1'b0;
            req_s2_q   <= 1'b0;
            op_rd_q    <= 1'b0;
            word_cnt_q <= 8'd0;
            wait_cnt_q <= 2'd0;
            rd_addr_q  <= 8'd0;
            app_addr_q <= 28'd0;
            app_cmd_q  <= 3'd0;
            app_en_q   <= 1'b0;
            wren_q     <= 1'b0;
            wdata_q    <= 128'd0;
            pg_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
            n_pgs_q    <= 32'd0;
            n_bad_q    <= 16'd0;
`ifdef HBUF_PG_READ_EN
            rd_cnt_q  <= 8'd0;
            rd_all_q  <= 1'b0;
            wr_addr_q <= 8'd0;
            wr_data_q <= 128'd0;
            wr_en_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            req_s1_q   <= req_s1_d;
            req_s2_q   <= req_s2_d;
            op_rd_q    <= op_rd_d;
            word_cnt_q <= word_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            rd_addr_q  <= rd_addr_d;
            app_addr_q <= app_addr_d;
            app_cmd_q  <= app_cmd_d;
            app_en_q   <= app_en_d;
            wren_q     <= wren_d;
            wdata_q    <= wdata_d;
            pg_ack_q   <= pg_ack_d;
            busy_q     <= busy_d;
            n_pgs_q    <= n_pgs_d;
            n_bad_q    <= n_bad_d;
`ifdef HBUF_PG_READ_EN
            rd_cnt_q  <= rd_cnt_d;
            rd_all_q  <= rd_all_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
`endif
        end
    end

    assign bus.pg_ack        = pg_ack_q;
    assign bus.dpram_rd_addr = rd_addr_q;
    assign bus.app_addr      = app_addr_q;
    assign bus.app_cmd       = app_cmd_q;
    assign bus.app_en        = app_en_q;
    assign bus.app_wdf_data  = wdata_q;
    assign bus.app_wdf_wren  = wren_q;
    assign bus.app_wdf_end   = wren_q;
    assign bus.app_wdf_mask  = 16'd0;
    assign bus.busy          = busy_q;
    assign bus.n_pgs_done    = n_pgs_q;
    assign bus.n_bad_ops     = n_bad_q;
    assign bus.dbg_state     = state_q;
`ifdef HBUF_PG_READ_EN
    assign bus.dpram_wr_addr = wr_addr_q;
    assign bus.dpram_wr_data = wr_data_q;
    assign bus.dpram_wren    = wr_en_q;
`endif
endmodule

// File: tb/tb_hbuf_ddr3_pg_xfer.sv
// Directed bench for hbuf_ddr3_pg_xfer: DPRAM model (word k = k), MIG ready driver, beat monitor, scoreboard.
module tb_hbuf_ddr3_pg_xfer;
    localparam int LAT   = 2;
    localparam int WORDS = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hbuf_ddr3_pg_xfer_if bus();

    hbuf_ddr3_pg_xfer #(
        .P_PG_WORDS     (WORDS),
        .P_DPRAM_RD_LAT (LAT),
        .P_ADDR_INC     (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Page DPRAM model, read latency LAT, content word k = k
    logic [127:0] dp_s1;
    always @(posedge clk) begin
        dp_s1          <= 128'(bus.dpram_rd_addr);
        bus.dpram_dout <= dp_s1;
    end

    // Beat monitor
    logic [27:0]  got_a_q[$];
    logic [127:0] got_d_q[$];
    int   cyc = 0, first_cyc = 0, last_cyc = 0, ack_rises = 0, bad_cmd = 0, bad_end = 0;
    logic ack_prev = 1'b0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.app_en && bus.app_rdy) begin
            if (got_a_q.size() == 0) first_cyc <= cyc;
            last_cyc <= cyc;
            got_a_q.push_back(bus.app_addr);
            if (bus.app_cmd != 3'b000) bad_cmd <= bad_cmd + 1;
        end
        if (bus.app_wdf_wren && bus.app_wdf_rdy) begin
            got_d_q.push_back(bus.app_wdf_data);
            if (!bus.app_wdf_end) bad_end <= bad_end + 1;
        end
        if (bus.pg_ack && !ack_prev) ack_rises <= ack_rises + 1;
        ack_prev <= bus.pg_ack;
    end

    // MIG ready driver: mode 0 = always ready, mode 1 = app_rdy toggles, wdf_rdy low 5 cycles at word 10
    int mode = 0;
    initial begin
        int  hold = 0;
        bit  held = 0;
        bus.app_rdy     = 1'b1;
        bus.app_wdf_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (mode == 0) begin
                bus.app_rdy     = 1'b1;
                bus.app_wdf_rdy = 1'b1;
            end else begin
                bus.app_rdy = ~bus.app_rdy;
                if (!held && got_d_q.size() == 10) begin
                    held = 1;
                    hold = 5;
                end
                if (hold > 0) begin
                    bus.app_wdf_rdy = 1'b0;
                    hold--;
                end else begin
                    bus.app_wdf_rdy = 1'b1;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_sb();
        got_a_q.delete();
        got_d_q.delete();
    endtask

    task automatic start_pg(input logic [27:0] a, input logic op);
        @(negedge clk);
        bus.pg_addr   = a;
        bus.pg_optype = op;
        bus.pg_req    = 1'b1;
    endtask

    task automatic finish_pg(input string tag, input int budget);
        int t = 0;
        while (!bus.pg_ack && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_ack_hi"}, 128'(bus.pg_ack), 128'(1));
        bus.pg_req = 1'b0;
        t = 0;
        while (bus.pg_ack && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_ack_lo"}, 128'(bus.pg_ack), 128'(0));
    endtask

    task automatic chk_page(input string tag, input logic [27:0] base);
        logic [27:0] exp_a;
        chk({tag, "_n_cmd"}, 128'(got_a_q.size()), 128'(WORDS));
        chk({tag, "_n_dat"}, 128'(got_d_q.size()), 128'(WORDS));
        for (int k = 0; k < WORDS && k < got_a_q.size(); k++) begin
            exp_a = base + 28'(8 * k);
            chk($sformatf("%s_addr[%0d]", tag, k), 128'(got_a_q[k]), 128'(exp_a));
        end
        for (int k = 0; k < WORDS && k < got_d_q.size(); k++)
            chk($sformatf("%s_data[%0d]", tag, k), got_d_q[k], 128'(k));
        chk({tag, "_cmd_wr"}, 128'(bad_cmd), 128'(0));
        chk({tag, "_wdf_end"}, 128'(bad_end), 128'(0));
    endtask

    initial begin
        int a0;
        int t;
        bus.calib_done = 1'b1;
        bus.pg_req     = 1'b0;
        bus.pg_optype  = 1'b0;
        bus.pg_addr    = 28'd0;
`ifdef HBUF_PG_READ_EN
        bus.app_rd_data       = 128'd0;
        bus.app_rd_data_valid = 1'b0;
`endif
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(2);

        chk("rst_pg_ack",   128'(bus.pg_ack),        128'(0));
        chk("rst_app_en",   128'(bus.app_en),        128'(0));
        chk("rst_wren",     128'(bus.app_wdf_wren),  128'(0));
        chk("rst_busy",     128'(bus.busy),          128'(0));
        chk("rst_n_pgs",    128'(bus.n_pgs_done),    128'(0));
        chk("rst_n_bad",    128'(bus.n_bad_ops),     128'(0));
        chk("rst_app_addr", 128'(bus.app_addr),      128'(0));
        chk("rst_state",    128'(bus.dbg_state),     128'(0));
        chk("rst_mask",     128'(bus.app_wdf_mask),  128'(0));

        // Page 1: readies high, base 0x100
        clear_sb();
        a0 = ack_rises;
        start_pg(28'h100, 1'b0);
        cycles(4);
        chk("p1_busy", 128'(bus.busy), 128'(1));
        finish_pg("p1", 2000);
        chk_page("p1", 28'h100);
        chk("p1_ack_rises", 128'(ack_rises - a0), 128'(1));
        chk("p1_n_pgs", 128'(bus.n_pgs_done), 128'(1));
        chk("p1_beat_span", 128'(last_cyc - first_cyc), 128'(255 * (LAT + 2)));
        chk("p1_idle", 128'(bus.busy), 128'(0));

        // Page 2: ready stress
        clear_sb();
        mode = 1;
        start_pg(28'h2000, 1'b0);
        finish_pg("p2", 5000);
        mode = 0;
        chk_page("p2", 28'h2000);
        chk("p2_n_pgs", 128'(bus.n_pgs_done), 128'(2));

        // Page 3: async reset at word 100, then restart at a new address
        clear_sb();
        start_pg(28'h3000, 1'b0);
        t = 0;
        while (got_a_q.size() < 100 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("p3_reach_w100", 128'(got_a_q.size() >= 100), 128'(1));
        #2 rst = 1'b1;
        bus.pg_req = 1'b0;
        #1;
        chk("p3_rst_app_en", 128'(bus.app_en),       128'(0));
        chk("p3_rst_wren",   128'(bus.app_wdf_wren), 128'(0));
        chk("p3_rst_pg_ack", 128'(bus.pg_ack),       128'(0));
        chk("p3_rst_busy",   128'(bus.busy),         128'(0));
        chk("p3_rst_n_pgs",  128'(bus.n_pgs_done),   128'(0));
        @(negedge clk);
        rst = 1'b0;
        cycles(3);
        clear_sb();
        start_pg(28'h5000, 1'b0);
        finish_pg("p3b", 2000);
        chk_page("p3b", 28'h5000);
        chk("p3b_n_pgs", 128'(bus.n_pgs_done), 128'(1));

        // Page 4: request held off by calib_done
        clear_sb();
        bus.calib_done = 1'b0;
        start_pg(28'h7000, 1'b0);
        cycles(20);
        chk("p4_no_cmd", 128'(got_a_q.size()), 128'(0));
        chk("p4_no_busy", 128'(bus.busy), 128'(0));
        bus.calib_done = 1'b1;
        finish_pg("p4", 2000);
        chk_page("p4", 28'h7000);
        chk("p4_n_pgs", 128'(bus.n_pgs_done), 128'(2));

`ifndef HBUF_PG_READ_EN
        // Unsupported read op
        clear_sb();
        start_pg(28'h9000, 1'b1);
        t = 0;
        while (!bus.pg_ack && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("bad_ack_fast", 128'(t <= 5), 128'(1));
        finish_pg("bad", 20);
        bus.pg_optype = 1'b0;
        chk("bad_no_cmd", 128'(got_a_q.size()), 128'(0));
        chk("bad_n_bad", 128'(bus.n_bad_ops), 128'(1));
        chk("bad_n_pgs", 128'(bus.n_pgs_done), 128'(3));
`endif

        // Back-to-back pages across the 28-bit address wrap
        @(negedge clk);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(2);
        clear_sb();
        a0 = ack_rises;
        start_pg(28'hFFFFF00, 1'b0);
        finish_pg("w1", 2000);
        chk_page("w1", 28'hFFFFF00);
        clear_sb();
        start_pg(28'h0, 1'b0);
        finish_pg("w2", 2000);
        chk_page("w2", 28'h0);
        chk("w_ack_rises", 128'(ack_rises - a0), 128'(2));
        chk("w_n_pgs", 128'(bus.n_pgs_done), 128'(2));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: sim time exceeded, %0d/%0d passed so far", n_pass, n_chk);
        $fatal(1);
    end
endmodule
